ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe.sv | 161 ++++++++++++++++
 tb/tb_ex_mem_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a small access tracker: holds one captured instruction,
// issues its data-memory request once, and stalls upstream until the access completes.
module ex_mem_pipe #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          en,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic          ex_regWEN,
  input  logic [4:0]    ex_regtbw,
  input  logic          ex_memtoReg,
  input  logic          ex_dREN,
  input  logic          ex_dWEN,
  input  logic          ex_halt,
  input  logic [DW-1:0] ex_alu_out,
  input  logic [DW-1:0] ex_store_data,
  input  logic [DW-1:0] ex_npc,
  input  logic          dhit,
  input  logic [DW-1:0] dmemload,
  output logic          ex_mem_regWEN,
  output logic [4:0]    ex_mem_regtbw,
  output logic [DW-1:0] ex_mem_fwd_data,
  output logic          dmemREN,
  output logic          dmemWEN,
  output logic [DW-1:0] dmemaddr,
  output logic [DW-1:0] dmemstore,
  output logic          mem_valid,
  output logic          mem_memtoReg,
  output logic          mem_halt,
  output logic [DW-1:0] mem_npc,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            valid_reg, valid_next;
  logic            regwen_reg, regwen_next;
  logic [4:0]      regtbw_reg, regtbw_next;
  logic            memtoreg_reg, memtoreg_next;
  logic            dren_reg, dren_next;
  logic            dwen_reg, dwen_next;
  logic            halt_reg, halt_next;
  logic [DW-1:0]   alu_reg, alu_next;
  logic [DW-1:0]   store_reg, store_next;
  logic [DW-1:0]   npc_reg, npc_next;
  logic [DW-1:0]   rdata_reg, rdata_next;

  logic            in_req;
  logic            completing;
  logic            advance;

  assign in_req     = (state_reg == REQ);
  assign completing = in_req && dhit;
  // A pending access blocks advance until its dhit, so it is never aborted or duplicated.
  assign advance    = en && (!in_req || dhit);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      valid_reg    <= 1'b0;
      regwen_reg   <= 1'b0;
      regtbw_reg   <= '0;
      memtoreg_reg <= 1'b0;
      dren_reg     <= 1'b0;
      dwen_reg     <= 1'b0;
      halt_reg     <= 1'b0;
      alu_reg      <= '0;
      store_reg    <= '0;
      npc_reg      <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      valid_reg    <= valid_next;
      regwen_reg   <= regwen_next;
      regtbw_reg   <= regtbw_next;
      memtoreg_reg <= memtoreg_next;
      dren_reg     <= dren_next;
      dwen_reg     <= dwen_next;
      halt_reg     <= halt_next;
      alu_reg      <= alu_next;
      store_reg    <= store_next;
      npc_reg      <= npc_next;
      rdata_reg    <= rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    valid_next    = valid_reg;
    regwen_next   = regwen_reg;
    regtbw_next   = regtbw_reg;
    memtoreg_next = memtoreg_reg;
    dren_next     = dren_reg;
    dwen_next     = dwen_reg;
    halt_next     = halt_reg;
    alu_next      = alu_reg;
    store_next    = store_reg;
    npc_next      = npc_reg;
    rdata_next    = rdata_reg;

    // Load data is latched on completion even when the next instruction enters on the same edge.
    if (completing && dren_reg) begin
      rdata_next = dmemload;
    end

    if (advance) begin
      if (flush) begin
        state_next    = IDLE;
        valid_next    = 1'b0;
        regwen_next   = 1'b0;
        regtbw_next   = '0;
        memtoreg_next = 1'b0;
        dren_next     = 1'b0;
        dwen_next     = 1'b0;
        halt_next     = 1'b0;
        alu_next      = '0;
        store_next    = '0;
        npc_next      = '0;
      end else begin
        state_next    = (ex_valid && (ex_dREN || ex_dWEN)) ? REQ : IDLE;
        valid_next    = ex_valid;
        regwen_next   = ex_regWEN;
        regtbw_next   = ex_regtbw;
        memtoreg_next = ex_memtoReg;
        dren_next     = ex_dREN;
        dwen_next     = ex_dWEN;
        halt_next     = ex_halt;
        alu_next      = ex_alu_out;
        store_next    = ex_store_data;
        npc_next      = ex_npc;
      end
    end else if (completing) begin
      state_next = DONE;
    end
  end

  assign dmemREN         = in_req && dren_reg;
  assign dmemWEN         = in_req && dwen_reg;
  assign dmemaddr        = alu_reg;
  assign dmemstore       = store_reg;
  assign mem_busy        = in_req && !dhit;

  assign ex_mem_regWEN   = regwen_reg && valid_reg;
  assign ex_mem_regtbw   = valid_reg ? regtbw_reg : 5'd0;
  assign ex_mem_fwd_data = alu_reg;

  assign mem_valid       = valid_reg;
  assign mem_memtoReg    = memtoreg_reg;
  assign mem_halt        = halt_reg;
  assign mem_npc         = npc_reg;
  assign mem_rdata       = rdata_reg;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed and randomized checks of ex_mem_pipe against an instruction-level reference model.
module tb_ex_mem_pipe;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          en, flush, ex_valid, ex_regWEN, ex_memtoReg, ex_dREN, ex_dWEN, ex_halt;
  logic [4:0]    ex_regtbw;
  logic [DW-1:0] ex_alu_out, ex_store_data, ex_npc;
  logic          dhit;
  logic [DW-1:0] dmemload;
  logic          ex_mem_regWEN, dmemREN, dmemWEN, mem_valid, mem_memtoReg, mem_halt, mem_busy;
  logic [4:0]    ex_mem_regtbw;
  logic [DW-1:0] ex_mem_fwd_data, dmemaddr, dmemstore, mem_npc, mem_rdata;

  int tests = 0;
  int fails = 0;

  // Reference model: the instruction currently held, and whether its access is still outstanding.
  logic          m_valid, m_regWEN, m_memtoReg, m_dREN, m_dWEN, m_halt;
  logic [4:0]    m_regtbw;
  logic [DW-1:0] m_alu, m_store, m_npc, m_rdata;
  logic          m_pending;
  logic          m_known;

  always #5 CLK = ~CLK;

  ex_mem_pipe #(.DW(DW)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .ex_valid(ex_valid), .ex_regWEN(ex_regWEN), .ex_regtbw(ex_regtbw),
    .ex_memtoReg(ex_memtoReg), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_halt(ex_halt),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_npc(ex_npc),
    .dhit(dhit), .dmemload(dmemload),
    .ex_mem_regWEN(ex_mem_regWEN), .ex_mem_regtbw(ex_mem_regtbw), .ex_mem_fwd_data(ex_mem_fwd_data),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_valid(mem_valid), .mem_memtoReg(mem_memtoReg), .mem_halt(mem_halt),
    .mem_npc(mem_npc), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_valid, m_regWEN, m_memtoReg, m_dREN, m_dWEN, m_halt, m_pending} = '0;
    m_regtbw = '0;
    m_alu = '0; m_store = '0; m_npc = '0; m_rdata = '0;
    m_known = 1'b1;
  endtask

  // Called right after a rising edge, using the inputs that were present at that edge.
  task automatic model_step();
    logic adv;
    adv = en && (!m_pending || dhit);
    if (m_pending && dhit && m_dREN) m_rdata = dmemload;
    if (adv && flush) begin
      {m_valid, m_regWEN, m_memtoReg, m_dREN, m_dWEN, m_halt, m_pending} = '0;
      m_regtbw = '0;
      m_known  = 1'b0;
    end else if (adv) begin
      m_valid = ex_valid; m_regWEN = ex_regWEN; m_regtbw = ex_regtbw;
      m_memtoReg = ex_memtoReg; m_dREN = ex_dREN; m_dWEN = ex_dWEN; m_halt = ex_halt;
      m_alu = ex_alu_out; m_store = ex_store_data; m_npc = ex_npc;
      m_pending = ex_valid && (ex_dREN || ex_dWEN);
      m_known = 1'b1;
    end else if (m_pending && dhit) begin
      m_pending = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("ex_mem_regWEN", ex_mem_regWEN, m_regWEN && m_valid);
    chk("ex_mem_regtbw", ex_mem_regtbw, m_valid ? m_regtbw : 5'd0);
    chk("dmemREN", dmemREN, m_pending && m_dREN);
    chk("dmemWEN", dmemWEN, m_pending && m_dWEN);
    chk("mem_busy", mem_busy, m_pending && !dhit);
    chk("mem_valid", mem_valid, m_valid);
    chk("mem_memtoReg", mem_memtoReg, m_memtoReg);
    chk("mem_halt", mem_halt, m_halt);
    chk("mem_rdata", mem_rdata, m_rdata);
    if (m_known) begin
      chk("fwd_data", ex_mem_fwd_data, m_alu);
      chk("dmemaddr", dmemaddr, m_alu);
      chk("dmemstore", dmemstore, m_store);
      chk("mem_npc", mem_npc, m_npc);
    end
  endtask

  // Checks the settled outputs, then takes one clock edge and advances the model.
  task automatic cycle();
    #1;
    check_all();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic [4:0] rd, input logic m2r,
                        input logic rd_en, input logic wr_en, input logic [DW-1:0] alu,
                        input logic [DW-1:0] sd);
    ex_valid = v; ex_regWEN = rw; ex_regtbw = rd; ex_memtoReg = m2r;
    ex_dREN = rd_en; ex_dWEN = wr_en; ex_halt = 1'b0;
    ex_alu_out = alu; ex_store_data = sd; ex_npc = alu + 32'd4;
  endtask

  initial begin
    nRST = 1'b0; en = 0; flush = 0; dhit = 0; dmemload = '0;
    set_ex(0, 0, 5'd0, 0, 0, 0, '0, '0);
    model_reset();
    #1;
    check_all();
    chk("reset_regWEN", ex_mem_regWEN, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    // ALU op forwarded next cycle
    en = 1;
    set_ex(1, 1, 5'd8, 0, 0, 0, 32'h10, 32'h0);
    cycle();
    $display("[TB] alu op captured rd=%0d fwd=%h", ex_mem_regtbw, ex_mem_fwd_data);
    chk("alu_regWEN", ex_mem_regWEN, 1'b1);
    chk("alu_regtbw", ex_mem_regtbw, 5'd8);
    chk("alu_fwd", ex_mem_fwd_data, 32'h10);
    chk("alu_busy", mem_busy, 1'b0);

    // Load with three-cycle latency
    set_ex(1, 1, 5'd3, 1, 1, 0, 32'h100, 32'h0);
    cycle();
    set_ex(0, 0, 5'd0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ld_wait_ren", dmemREN, 1'b1);
      chk("ld_wait_busy", mem_busy, 1'b1);
      chk("ld_addr", dmemaddr, 32'h100);
      cycle();
    end
    en = 0; dhit = 1; dmemload = 32'hDEAD;
    #1;
    chk("ld_hit_busy", mem_busy, 1'b0);
    cycle();
    dhit = 0;
    $display("[TB] load completed rdata=%h", mem_rdata);
    chk("ld_rdata", mem_rdata, 32'hDEAD);
    chk("ld_ren_after", dmemREN, 1'b0);

    // Held stage: no repeated request after completion
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("hold_ren", dmemREN, 1'b0);
      chk("hold_rd", ex_mem_regtbw, 5'd3);
      chk("hold_rdata", mem_rdata, 32'hDEAD);
    end
    $display("[TB] hold for 4 cycles done");

    // Load completes on the same edge the next instruction enters
    en = 1;
    set_ex(1, 1, 5'd4, 1, 1, 0, 32'h200, 32'h0);
    cycle();
    set_ex(1, 1, 5'd9, 0, 0, 0, 32'h55, 32'h0);
    dhit = 1; dmemload = 32'hBEEF;
    cycle();
    dhit = 0;
    $display("[TB] hit+advance rdata=%h rd=%0d", mem_rdata, ex_mem_regtbw);
    chk("same_rdata", mem_rdata, 32'hBEEF);
    chk("same_rd", ex_mem_regtbw, 5'd9);
    chk("same_fwd", ex_mem_fwd_data, 32'h55);
    chk("same_ren", dmemREN, 1'b0);

    // Flush in IDLE produces a bubble
    flush = 1;
    set_ex(1, 1, 5'd7, 0, 0, 0, 32'h77, 32'h0);
    cycle();
    $display("[TB] flush in idle valid=%0b", mem_valid);
    chk("flush_regWEN", ex_mem_regWEN, 1'b0);
    chk("flush_rd", ex_mem_regtbw, 5'd0);
    chk("flush_valid", mem_valid, 1'b0);

    // Flush while an access is outstanding is ignored
    flush = 0;
    set_ex(1, 0, 5'd0, 0, 0, 1, 32'h180, 32'h1234);
    cycle();
    flush = 1;
    set_ex(1, 1, 5'd2, 0, 0, 0, 32'h9, 32'h0);
    cycle();
    $display("[TB] flush during access wen=%0b valid=%0b", dmemWEN, mem_valid);
    chk("flushreq_wen", dmemWEN, 1'b1);
    chk("flushreq_valid", mem_valid, 1'b1);
    chk("flushreq_store", dmemstore, 32'h1234);
    flush = 0; en = 0; dhit = 1;
    cycle();
    dhit = 0;

    // Asynchronous reset in the middle of a store
    en = 1;
    set_ex(1, 0, 5'd0, 0, 0, 1, 32'h300, 32'hCAFE);
    cycle();
    en = 0;
    #1;
    chk("st_wen", dmemWEN, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    $display("[TB] reset mid-store wen=%0b", dmemWEN);
    chk("rst_wen", dmemWEN, 1'b0);
    chk("rst_addr", dmemaddr, 32'h0);
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    nRST = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int kind;
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      dhit  = ($urandom_range(0, 9) < 4);
      dmemload = $urandom;
      kind = $urandom_range(0, 3);
      set_ex($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
             $urandom_range(0, 1) == 1, kind == 1, kind == 2, $urandom, $urandom);
      ex_halt = ($urandom_range(0, 15) == 0);
      if (en && (!m_pending || dhit))
        $display("[TB] rnd %0d advance flush=%0b valid=%0b ren=%0b wen=%0b rd=%0d",
                 c, flush, ex_valid, ex_dREN, ex_dWEN, ex_regtbw);
      cycle();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        $display("[TB] rnd %0d async reset pulse", c);
      end
    end
    #1;
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
